// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS-style datapath slice.
//   - DATA_WIDTH / REG_ADDR_WIDTH / ALU_OP_WIDTH : default datapath widths
//   - SHAMT_WIDTH                                : shift-amount field width
//   - alu_op_e                                   : ALU operation encodings
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int ALU_OP_WIDTH   = 4;
    localparam int SHAMT_WIDTH    = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_NOR = 4'b0010,
        ALU_ADD = 4'b0011,
        ALU_LUI = 4'b0101,
        ALU_SLL = 4'b0110,
        ALU_SRL = 4'b0111,
        ALU_SUB = 4'b1000
    } alu_op_e;

endpackage : mips_pkg

// File: rtl/forward_unit.sv
// ---------------------------------------------------------------------------
// forward_unit
// Combinational operand select for one EX source operand. Picks the newest
// in-flight value of the source register: EX/MEM result first, then MEM/WB
// result, otherwise the value read from the register file at decode.
// Register 0 is hard-wired zero, so it is never forwarded.
//
// Ports:
//   i_src_idx        source register index held in ID/EX
//   i_src_data       register file data held in ID/EX
//   i_exmem_we       EX/MEM stage will write a register
//   i_exmem_dest     EX/MEM destination index
//   i_exmem_result   EX/MEM result value
//   i_memwb_we       MEM/WB stage will write a register
//   i_memwb_dest     MEM/WB destination index
//   i_memwb_result   MEM/WB result value
//   o_data           selected operand
// ---------------------------------------------------------------------------
module forward_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] i_src_idx,
    input  logic [DATA_W-1:0] i_src_data,
    input  logic              i_exmem_we,
    input  logic [ADDR_W-1:0] i_exmem_dest,
    input  logic [DATA_W-1:0] i_exmem_result,
    input  logic              i_memwb_we,
    input  logic [ADDR_W-1:0] i_memwb_dest,
    input  logic [DATA_W-1:0] i_memwb_result,
    output logic [DATA_W-1:0] o_data
);

    logic w_exmem_hit;
    logic w_memwb_hit;

    assign w_exmem_hit = i_exmem_we && (i_exmem_dest != '0) && (i_exmem_dest == i_src_idx);
    assign w_memwb_hit = i_memwb_we && (i_memwb_dest != '0) && (i_memwb_dest == i_src_idx);

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    always_comb begin
        o_data = i_src_data;
        if (w_exmem_hit) begin
            o_data = i_exmem_result;
        end else if (w_memwb_hit) begin
            o_data = i_memwb_result;
        end
    end

endmodule : forward_unit

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register that feeds the ALU. Captures decoded operands and
// control each cycle, forwards from EX/MEM and MEM/WB onto the registered
// operands, and raises a one-cycle load-use stall toward PC/IF-ID.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   id_*                         decoded instruction from the decode stage
//   flush                        squash the instruction entering EX
//   ex_hold                      downstream stall, freeze EX contents
//   exmem_* / memwb_*            forwarding sources (write enable, dest, value)
//   stall                        load-use stall request (combinational)
//   alu_operation/shamt/a/b      ALU inputs
//   ex_valid, ex_dest            EX instruction valid and destination index
//   ex_store_data                forwarded rt value for stores
//   ex_reg_write .. ex_mem_to_reg pass-through control for MEM
//
// Register update priority per edge: reset > flush > ex_hold > stall > load.
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_WIDTH     = mips_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = mips_pkg::REG_ADDR_WIDTH,
    parameter int ALU_OP_WIDTH   = mips_pkg::ALU_OP_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic [DATA_WIDTH-1:0]     id_rs_data,
    input  logic [DATA_WIDTH-1:0]     id_rt_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [4:0]                id_shamt,
    input  logic [ALU_OP_WIDTH-1:0]   id_alu_op,
    input  logic                      id_alu_src,
    input  logic                      id_uses_rt,
    input  logic                      id_reg_dst,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic                      id_mem_to_reg,

    input  logic                      flush,
    input  logic                      ex_hold,

    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_dest,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_dest,
    input  logic [DATA_WIDTH-1:0]     memwb_result,

    output logic                      stall,
    output logic [ALU_OP_WIDTH-1:0]   alu_operation,
    output logic [4:0]                alu_shamt,
    output logic [DATA_WIDTH-1:0]     alu_a,
    output logic [DATA_WIDTH-1:0]     alu_b,
    output logic                      ex_valid,
    output logic [REG_ADDR_WIDTH-1:0] ex_dest,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic                      ex_mem_to_reg
);

    // Pipeline registers
    logic                      r_valid;
    logic [REG_ADDR_WIDTH-1:0] r_rs;
    logic [REG_ADDR_WIDTH-1:0] r_rt;
    logic [REG_ADDR_WIDTH-1:0] r_dest;
    logic [DATA_WIDTH-1:0]     r_rs_data;
    logic [DATA_WIDTH-1:0]     r_rt_data;
    logic [DATA_WIDTH-1:0]     r_imm;
    logic [4:0]                r_shamt;
    logic [ALU_OP_WIDTH-1:0]   r_alu_op;
    logic                      r_alu_src;
    logic                      r_reg_write;
    logic                      r_mem_read;
    logic                      r_mem_write;
    logic                      r_mem_to_reg;

    logic                      w_stall;
    logic                      w_dep_rs;
    logic                      w_dep_rt;
    logic                      w_load_bubble;
    logic                      w_capture;
    logic [DATA_WIDTH-1:0]     w_fwd_rs;
    logic [DATA_WIDTH-1:0]     w_fwd_rt;

    // ------------------------------------------------------------------
    // Load-use hazard: the load in EX has no data until MEM, so a dependent
    // instruction in ID must wait one cycle. The next cycle the load sits in
    // EX/MEM and forwarding covers it, so the stall self-terminates. The
    // reset gate keeps stall low while a stale load still sits in EX.
    // ------------------------------------------------------------------
    assign w_dep_rs = (r_dest == id_rs);
    assign w_dep_rt = id_uses_rt && (r_dest == id_rt);

    assign w_stall = !reset && !flush && id_valid && r_valid && r_mem_read
                     && (r_dest != '0) && (w_dep_rs || w_dep_rt);

    assign stall = w_stall;

    // Bubble: flush always wins; otherwise only when not holding and either
    // stalling or the decode slot is empty.
    assign w_load_bubble = flush || (!ex_hold && (w_stall || !id_valid));
    assign w_capture     = !flush && !ex_hold && !w_stall && id_valid;

    always_ff @(posedge clk) begin
        if (reset || w_load_bubble) begin
            r_valid      <= 1'b0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_dest       <= '0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_shamt      <= '0;
            r_alu_op     <= ALU_OP_WIDTH'(mips_pkg::ALU_AND);
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (w_capture) begin
            r_valid      <= 1'b1;
            r_rs         <= id_rs;
            r_rt         <= id_rt;
            r_dest       <= id_reg_dst ? id_rd : id_rt;
            r_rs_data    <= id_rs_data;
            r_rt_data    <= id_rt_data;
            r_imm        <= id_imm;
            r_shamt      <= id_shamt;
            r_alu_op     <= id_alu_op;
            r_alu_src    <= id_alu_src;
            r_reg_write  <= id_reg_write;
            r_mem_read   <= id_mem_read;
            r_mem_write  <= id_mem_write;
            r_mem_to_reg <= id_mem_to_reg;
        end
        // ex_hold without flush: all registers keep their value.
    end

    // ------------------------------------------------------------------
    // Forwarding on the registered source indices
    // ------------------------------------------------------------------
    forward_unit #(
        .DATA_W (DATA_WIDTH),
        .ADDR_W (REG_ADDR_WIDTH)
    ) u_fwd_rs (
        .i_src_idx      (r_rs),
        .i_src_data     (r_rs_data),
        .i_exmem_we     (exmem_reg_write),
        .i_exmem_dest   (exmem_dest),
        .i_exmem_result (exmem_result),
        .i_memwb_we     (memwb_reg_write),
        .i_memwb_dest   (memwb_dest),
        .i_memwb_result (memwb_result),
        .o_data         (w_fwd_rs)
    );

    forward_unit #(
        .DATA_W (DATA_WIDTH),
        .ADDR_W (REG_ADDR_WIDTH)
    ) u_fwd_rt (
        .i_src_idx      (r_rt),
        .i_src_data     (r_rt_data),
        .i_exmem_we     (exmem_reg_write),
        .i_exmem_dest   (exmem_dest),
        .i_exmem_result (exmem_result),
        .i_memwb_we     (memwb_reg_write),
        .i_memwb_dest   (memwb_dest),
        .i_memwb_result (memwb_result),
        .o_data         (w_fwd_rt)
    );

    // ------------------------------------------------------------------
    // Outputs. Store data is the forwarded rt even when B takes the
    // immediate, since sw uses the immediate for the address.
    // ------------------------------------------------------------------
    assign alu_operation = r_alu_op;
    assign alu_shamt     = r_shamt;
    assign alu_a         = w_fwd_rs;
    assign alu_b         = r_alu_src ? r_imm : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;
    assign ex_valid      = r_valid;
    assign ex_dest       = r_dest;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_mem_to_reg = r_mem_to_reg;

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_uses_rt, id_reg_dst;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        flush, ex_hold;
    logic        exmem_reg_write;
    logic [4:0]  exmem_dest;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_dest;
    logic [31:0] memwb_result;

    logic        stall;
    logic [3:0]  alu_operation;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_a, alu_b;
    logic        ex_valid;
    logic [4:0]  ex_dest;
    logic [31:0] ex_store_data;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_shamt        (id_shamt),
        .id_alu_op       (id_alu_op),
        .id_alu_src      (id_alu_src),
        .id_uses_rt      (id_uses_rt),
        .id_reg_dst      (id_reg_dst),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_mem_to_reg   (id_mem_to_reg),
        .flush           (flush),
        .ex_hold         (ex_hold),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dest      (exmem_dest),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dest      (memwb_dest),
        .memwb_result    (memwb_result),
        .stall           (stall),
        .alu_operation   (alu_operation),
        .alu_shamt       (alu_shamt),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .ex_valid        (ex_valid),
        .ex_dest         (ex_dest),
        .ex_store_data   (ex_store_data),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_to_reg   (ex_mem_to_reg)
    );

    // Reference model: the instruction sitting in EX, as a plain record.
    typedef struct {
        bit        v;
        bit [4:0]  rs, rt, dest, sh;
        bit [31:0] rsd, rtd, imm;
        bit [3:0]  op;
        bit        src, rw, mr, mw, mtr;
    } ex_t;

    ex_t m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] fwd(input bit [4:0] idx, input bit [31:0] d);
        if (exmem_reg_write && exmem_dest != 0 && exmem_dest == idx) return exmem_result;
        if (memwb_reg_write && memwb_dest != 0 && memwb_dest == idx) return memwb_result;
        return d;
    endfunction

    function automatic bit model_stall();
        if (reset || flush || !id_valid || !m.v || !m.mr || m.dest == 0) return 1'b0;
        return (m.dest == id_rs) || (id_uses_rt && m.dest == id_rt);
    endfunction

    task automatic clear_model();
        m = '{default: 0};
    endtask

    // Compare all outputs against the model, then advance one clock.
    task automatic cycle();
        bit st;
        #1;
        st = model_stall();
        chk("stall", {31'd0, stall}, {31'd0, st});
        chk("alu_operation", {28'd0, alu_operation}, {28'd0, m.op});
        chk("alu_shamt", {27'd0, alu_shamt}, {27'd0, m.sh});
        chk("alu_a", alu_a, fwd(m.rs, m.rsd));
        chk("alu_b", alu_b, m.src ? m.imm : fwd(m.rt, m.rtd));
        chk("ex_store_data", ex_store_data, fwd(m.rt, m.rtd));
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.v});
        chk("ex_dest", {27'd0, ex_dest}, {27'd0, m.dest});
        chk("ex_ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
            {28'd0, m.rw, m.mr, m.mw, m.mtr});
        @(posedge clk);
        if (reset || flush) clear_model();
        else if (ex_hold) ;
        else if (st || !id_valid) clear_model();
        else begin
            m.v = 1; m.rs = id_rs; m.rt = id_rt; m.dest = id_reg_dst ? id_rd : id_rt;
            m.rsd = id_rs_data; m.rtd = id_rt_data; m.imm = id_imm; m.sh = id_shamt;
            m.op = id_alu_op; m.src = id_alu_src; m.rw = id_reg_write; m.mr = id_mem_read;
            m.mw = id_mem_write; m.mtr = id_mem_to_reg;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0; id_alu_op = 0;
        id_alu_src = 0; id_uses_rt = 0; id_reg_dst = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        flush = 0; ex_hold = 0;
        exmem_reg_write = 0; exmem_dest = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_dest = 0; memwb_result = 0;
    endtask

    task automatic set_rtype(input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                             input bit [31:0] rsd, input bit [31:0] rtd);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
        id_alu_op = 4'b0011; id_alu_src = 0; id_uses_rt = 1; id_reg_dst = 1;
        id_reg_write = 1; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    endtask

    task automatic set_lw(input bit [4:0] rs, input bit [4:0] rt);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = 0; id_rs_data = 32'h100; id_rt_data = 0;
        id_imm = 32'h4; id_alu_op = 4'b0011; id_alu_src = 1; id_uses_rt = 0; id_reg_dst = 0;
        id_reg_write = 1; id_mem_read = 1; id_mem_write = 0; id_mem_to_reg = 1;
    endtask

    initial begin
        idle();
        clear_model();
        reset = 1;
        @(negedge clk);
        cycle();
        reset = 0;
        #1;
        chk("reset_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset_alu_b", alu_b, 32'd0);

        // Capture an add
        set_rtype(5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        cycle();
        idle();
        #1;
        chk("add_alu_a", alu_a, 32'd5);
        chk("add_alu_b", alu_b, 32'd7);
        chk("add_op", {28'd0, alu_operation}, 32'h3);
        chk("add_valid", {31'd0, ex_valid}, 32'd1);
        cycle();

        // Forwarding priority on rs=3
        set_rtype(5'd3, 5'd6, 5'd7, 32'h11, 32'h22);
        cycle();
        idle();
        exmem_reg_write = 1; exmem_dest = 3; exmem_result = 32'hAAAA;
        memwb_reg_write = 1; memwb_dest = 3; memwb_result = 32'hBBBB;
        #1 chk("fwd_exmem_prio", alu_a, 32'hAAAA);
        exmem_reg_write = 0;
        #1 chk("fwd_memwb", alu_a, 32'hBBBB);
        cycle();

        // Register 0 guard
        idle();
        set_rtype(5'd0, 5'd6, 5'd7, 32'h77, 32'h22);
        cycle();
        idle();
        exmem_reg_write = 1; exmem_dest = 0; exmem_result = 32'h1234;
        #1 chk("r0_no_fwd", alu_a, 32'h77);
        cycle();

        // sw: B is the immediate, store data is forwarded rt
        idle();
        set_rtype(5'd1, 5'd5, 5'd0, 32'h10, 32'h99);
        id_alu_src = 1; id_imm = 32'd8; id_reg_write = 0; id_mem_write = 1; id_reg_dst = 0;
        cycle();
        idle();
        memwb_reg_write = 1; memwb_dest = 5; memwb_result = 32'h55;
        #1;
        chk("sw_alu_b", alu_b, 32'd8);
        chk("sw_store", ex_store_data, 32'h55);
        cycle();

        // Load-use on rs: one stall cycle, bubble, then the add enters
        idle();
        set_lw(5'd1, 5'd4);
        cycle();
        set_rtype(5'd4, 5'd2, 5'd9, 32'h1, 32'h2);
        #1 chk("lu_stall", {31'd0, stall}, 32'd1);
        cycle();
        #1;
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu_stall_end", {31'd0, stall}, 32'd0);
        cycle();
        #1 chk("lu_enter", {27'd0, ex_dest}, 32'd9);
        idle();
        cycle();

        // rt match but rt unused: no stall
        set_lw(5'd1, 5'd4);
        cycle();
        set_rtype(5'd2, 5'd4, 5'd9, 32'h1, 32'h2);
        id_uses_rt = 0;
        #1 chk("lu_rt_unused", {31'd0, stall}, 32'd0);
        cycle();

        // Flush overrides the load-use stall
        idle();
        set_lw(5'd1, 5'd4);
        cycle();
        set_rtype(5'd4, 5'd2, 5'd9, 32'h1, 32'h2);
        flush = 1;
        #1 chk("flush_no_stall", {31'd0, stall}, 32'd0);
        cycle();
        flush = 0;
        #1 chk("flush_bubble", {31'd0, ex_valid}, 32'd0);

        // Hold for three cycles: id_* changes ignored
        set_rtype(5'd1, 5'd2, 5'd3, 32'h21, 32'h31);
        cycle();
        ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            set_rtype(5'($urandom_range(1, 7)), 5'd2, 5'd3, $urandom, $urandom);
            cycle();
            #1 chk("hold_alu_a", alu_a, 32'h21);
        end
        ex_hold = 0;
        idle();

        // Reset while EX holds a valid load that would stall ID
        set_lw(5'd1, 5'd4);
        cycle();
        set_rtype(5'd4, 5'd2, 5'd9, 32'h1, 32'h2);
        reset = 1;
        #1 chk("rst_no_stall", {31'd0, stall}, 32'd0);
        cycle();
        reset = 0;
        idle();
        #1;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_mem_read", {31'd0, ex_mem_read}, 32'd0);

        // Randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 49) == 0);
            flush           = ($urandom_range(0, 7) == 0);
            ex_hold         = ($urandom_range(0, 5) == 0);
            id_valid        = ($urandom_range(0, 7) != 0);
            id_rs           = 5'($urandom_range(0, 7));
            id_rt           = 5'($urandom_range(0, 7));
            id_rd           = 5'($urandom_range(0, 7));
            id_rs_data      = $urandom;
            id_rt_data      = $urandom;
            id_imm          = $urandom;
            id_shamt        = 5'($urandom);
            id_alu_op       = 4'($urandom);
            id_alu_src      = 1'($urandom);
            id_uses_rt      = 1'($urandom);
            id_reg_dst      = 1'($urandom);
            id_reg_write    = 1'($urandom);
            id_mem_read     = ($urandom_range(0, 2) == 0);
            id_mem_write    = 1'($urandom);
            id_mem_to_reg   = 1'($urandom);
            exmem_reg_write = 1'($urandom);
            exmem_dest      = 5'($urandom_range(0, 7));
            exmem_result    = $urandom;
            memwb_reg_write = 1'($urandom);
            memwb_dest      = 5'($urandom_range(0, 7));
            memwb_result    = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_id_ex_stage

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary that directly feeds the ALU.
- Registers decoded operands and control from the decode stage each cycle.
- Resolves data hazards by forwarding from EX/MEM and MEM/WB, and detects load-use hazards.
- Drives ALUOperation, Shamt, A and B for the ALU, plus pass-through control for the MEM stage.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- REG_ADDR_WIDTH, 5, register index width.
- ALU_OP_WIDTH, 4, ALU operation code width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode stage presents a real instruction
- id_rs, id_rt, id_rd  in  REG_ADDR_WIDTH each  source/dest indices
- id_rs_data, id_rt_data  in  DATA_WIDTH each  register file read data
- id_imm  in  DATA_WIDTH  extended immediate
- id_shamt  in  5  shift amount
- id_alu_op  in  ALU_OP_WIDTH  ALU operation code
- id_alu_src  in  1  1 = B operand is immediate
- id_uses_rt  in  1  instruction reads rt (R-type, beq/bne, sw)
- id_reg_dst  in  1  1 = dest is rd, else rt
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
- flush  in  1  branch/jump squash of the instruction entering EX
- ex_hold  in  1  downstream stall; freeze EX contents
- exmem_reg_write  in  1;  exmem_dest  in  REG_ADDR_WIDTH;  exmem_result  in  DATA_WIDTH
- memwb_reg_write  in  1;  memwb_dest  in  REG_ADDR_WIDTH;  memwb_result  in  DATA_WIDTH
- stall  out  1  load-use stall request to PC/IF-ID (combinational)
- alu_operation  out  ALU_OP_WIDTH;  alu_shamt  out  5;  alu_a, alu_b  out  DATA_WIDTH
- ex_valid  out  1;  ex_dest  out  REG_ADDR_WIDTH;  ex_store_data  out  DATA_WIDTH
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each

Behaviour:
- Reset (synchronous): every register clears to 0. The resulting outputs are alu_operation=AND(0), alu_a=alu_b=0, ex_valid=0 and all ex_* control=0. stall=0 while reset=1.
- Register update priority, per clock edge: reset > flush > ex_hold > stall > load.
  - flush: load a bubble (valid and all control bits=0, data registers=0).
  - ex_hold (no flush): keep every register unchanged.
  - stall (no flush, no hold): load a bubble; the upstream stage holds its own contents.
  - otherwise: capture all id_* fields. ex_dest = id_reg_dst ? id_rd : id_rt.
- Bubble rule: id_valid=0 is captured as a bubble, with control bits forced to 0.
- Load-use stall (combinational):
  - stall = id_valid & ex_valid & ex_mem_read & ex_dest!=0 & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt)) & ~flush.
  - A stall lasts exactly one cycle: the load advances to MEM, where the next cycle's forwarding covers it.
  - While ex_hold=1, stall is still evaluated from the held EX contents.
- Forwarding (combinational, on registered operands):
  - For the rs operand: if exmem_reg_write & exmem_dest!=0 & exmem_dest==rs_q, use exmem_result. Else if memwb_reg_write & memwb_dest!=0 & memwb_dest==rs_q, use memwb_result. Else use rs_data_q.
  - The rt operand is forwarded the same way; EX/MEM always has priority over MEM/WB.
  - Register 0 is never forwarded.
- Operand mapping:
  - alu_a = forwarded rs.
  - alu_b = alu_src_q ? imm_q : forwarded rt.
  - ex_store_data = forwarded rt, always, regardless of alu_src.
  - alu_shamt = shamt_q; alu_operation = alu_op_q.
- Latency: one cycle from an id_* capture to the ALU inputs. No combinational path from id_* to alu_* outputs.
- Outputs during a bubble: alu_* outputs show the cleared registers (0). The ALU's Zero flag has no meaning when ex_valid=0.

Decomposition:
- Shared package mips_pkg holds the ALU op constants: AND=0000, OR=0001, NOR=0010, ADD=0011, LUI=0101, SLL=0110, SRL=0111, SUB=1000. It also holds REG_ADDR_WIDTH and DATA_WIDTH.
- One sub-module, forward_unit: combinational operand select, instantiated twice (rs, rt). Inputs are the source index, registered data, and the EX/MEM and MEM/WB triples; output is the selected data.
- The hazard compare and the pipeline register stay in id_ex_stage.

Test Plan:
- Reset, then capture add: id_rs_data=5, id_rt_data=7, id_alu_op=ADD, alu_src=0 -> next cycle alu_a=5, alu_b=7, alu_operation=0011, ex_valid=1.
- Forwarding priority: rs_q=3, exmem (we=1, dest=3, result=0xAAAA) and memwb (we=1, dest=3, result=0xBBBB) -> alu_a=0xAAAA. Deassert exmem_reg_write -> alu_a=0xBBBB.
- Register 0 guard: rs_q=0, exmem (dest=0, we=1, result=0x1234) -> alu_a=rs_data_q. Also sw with alu_src=1, imm=8, rt forwarded 0x55 -> alu_b=8, ex_store_data=0x55.
- Load-use: EX holds lw (mem_read=1, dest=4) and ID holds add with rs=4 -> stall=1 for exactly one cycle, next EX is a bubble (ex_valid=0), then the add enters. Same with rt=4 but id_uses_rt=0 -> stall=0.
- Flush vs stall vs hold: flush=1 during a load-use condition -> stall=0 and a bubble is loaded. ex_hold=1 for 3 cycles -> alu_* outputs unchanged, id_* changes ignored.
- Mid-operation reset: reset=1 while EX holds a valid lw -> next cycle all outputs 0, stall=0.
